i2c_master_arbiter: RTL and testbench

//  Shares one I2C/PMBus byte master (send_en/recv_en + done_flag handshake) between N_REQ command sequencers,
//  e.g. several LTC2992 monitors, using round-robin arbitration. Sits between the per-device command FSMs and the master.

---
 rtl/i2c_arb_pkg.sv | 24 ++
 rtl/i2c_master_arbiter_rr_pick.sv | 30 +++
 rtl/i2c_master_arbiter.sv | 229 ++++++++++++++++++++++
 tb/tb_i2c_master_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_arb_pkg.sv
// Shared types and constants for the I2C/PMBus master arbiter.
package i2c_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_RELEASE
   } arb_state_e;

   // 50 MHz clk_sys tick counts
   localparam int unsigned T_10ms  = 32'd500_000;
   localparam int unsigned T_20ms  = 32'd1_000_000;
   localparam int unsigned T_50ms  = 32'd2_500_000;
   localparam int unsigned T_100ms = 32'd5_000_000;
   localparam int unsigned T_150ms = 32'd7_500_000;

   localparam int DEV_W  = 7;
   localparam int WORD_W = 8;
   localparam int DATA_W = 8;
   localparam int BYTE_W = 2;
   localparam int RD_W   = 16;

endpackage

// File: rtl/i2c_master_arbiter_rr_pick.sv
// rr_pick: combinational rotating-priority encoder; the first requester at or
// after ptr_i (wrapping) wins.
module rr_pick #(
   parameter int N_REQ = 4,
   parameter int IDX_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic [N_REQ-1:0] gnt_o,
   output logic             valid_o
);

   logic found;

   always_comb begin
      gnt_o = '0;
      found = 1'b0;
      for (int k = 0; k < N_REQ; k++) begin
         for (int i = 0; i < N_REQ; i++) begin
            if (!found && req_i[i] && (i == (int'(ptr_i) + k) % N_REQ)) begin
               gnt_o[i] = 1'b1;
               found    = 1'b1;
            end
         end
      end
   end

   assign valid_o = |req_i;

endmodule

// File: rtl/i2c_master_arbiter.sv
// Round-robin sharing of one I2C/PMBus byte master between N_REQ sequencers.
// Optional WAIT watchdog is built in when ARB_TIMEOUT_EN is defined.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | no owner; pick next requester from the round-robin pointer
// ST_ISSUE   | owner and fields latched; raise send/recv enable
// ST_WAIT    | enable held, fields frozen, waiting for master done
// ST_RELEASE | done pulsed; wait for owner to drop its request
module i2c_master_arbiter
   import i2c_arb_pkg::*;
#(
   parameter int          N_REQ       = 4,
   parameter logic [23:0] TIMEOUT_CYC = 24'd5_000_000
) (
   input  logic                      I_clk,
   input  logic                      I_rst,
   input  logic [N_REQ-1:0]          I_req_send,
   input  logic [N_REQ-1:0]          I_req_recv,
   input  logic [DEV_W*N_REQ-1:0]    I_req_dev_addr,
   input  logic [WORD_W*N_REQ-1:0]   I_req_word_addr,
   input  logic [DATA_W*N_REQ-1:0]   I_req_write_data,
   input  logic [BYTE_W*N_REQ-1:0]   I_req_byte,
   output logic [N_REQ-1:0]          O_grant,
   output logic [N_REQ-1:0]          O_req_done,
   output logic [N_REQ-1:0]          O_req_err,
   output logic [RD_W-1:0]           O_read_data,
   output logic                      O_send_en,
   output logic                      O_recv_en,
   output logic [DEV_W-1:0]          O_dev_addr,
   output logic [WORD_W-1:0]         O_word_addr,
   output logic [DATA_W-1:0]         O_write_data,
   output logic [BYTE_W-1:0]         O_byte,
   input  logic                      I_done_flag,
   input  logic [RD_W-1:0]           I_read_data
);

   localparam int IDX_W = $clog2(N_REQ);

   arb_state_e         state_q, state_d;
   logic [N_REQ-1:0]   grant_q, grant_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [IDX_W-1:0]   ptr_q, ptr_d;
   logic [DEV_W-1:0]   dev_q, dev_d;
   logic [WORD_W-1:0]  word_q, word_d;
   logic [DATA_W-1:0]  wdata_q, wdata_d;
   logic [BYTE_W-1:0]  byte_q, byte_d;
   logic               send_q, send_d;
   logic               send_en_q, send_en_d;
   logic               recv_en_q, recv_en_d;
   logic [N_REQ-1:0]   done_q, done_d;
   logic [RD_W-1:0]    rdata_q, rdata_d;

   logic [N_REQ-1:0]   req;
   logic [N_REQ-1:0]   pick_gnt;
   logic               pick_valid;
   logic [IDX_W-1:0]   pick_idx;
   logic [DEV_W-1:0]   pick_dev;
   logic [WORD_W-1:0]  pick_word;
   logic [DATA_W-1:0]  pick_wdata;
   logic [BYTE_W-1:0]  pick_byte;
   logic               pick_send;
   logic [IDX_W-1:0]   ptr_next;

`ifdef ARB_TIMEOUT_EN
   logic [N_REQ-1:0]   err_q, err_d;
   logic [23:0]        cnt_q, cnt_d;
`else
   logic               unused_timeout;
   assign unused_timeout = ^TIMEOUT_CYC;
`endif

   assign req = I_req_send | I_req_recv;

   rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
      .req_i   (req),
      .ptr_i   (ptr_q),
      .gnt_o   (pick_gnt),
      .valid_o (pick_valid)
   );

   // One-hot mux of the winning requester's fields; send wins over recv.
   always_comb begin
      pick_idx   = '0;
      pick_dev   = '0;
      pick_word  = '0;
      pick_wdata = '0;
      pick_byte  = '0;
      pick_send  = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         if (pick_gnt[i]) begin
            pick_idx   = IDX_W'(i);
            pick_dev   = I_req_dev_addr[i*DEV_W +: DEV_W];
            pick_word  = I_req_word_addr[i*WORD_W +: WORD_W];
            pick_wdata = I_req_write_data[i*DATA_W +: DATA_W];
            pick_byte  = I_req_byte[i*BYTE_W +: BYTE_W];
            pick_send  = I_req_send[i];
         end
      end
   end

   assign ptr_next = (idx_q == IDX_W'(N_REQ - 1)) ? '0 : idx_q + 1'b1;

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      idx_d     = idx_q;
      ptr_d     = ptr_q;
      dev_d     = dev_q;
      word_d    = word_q;
      wdata_d   = wdata_q;
      byte_d    = byte_q;
      send_d    = send_q;
      send_en_d = send_en_q;
      recv_en_d = recv_en_q;
      done_d    = '0;
      rdata_d   = rdata_q;
`ifdef ARB_TIMEOUT_EN
      err_d     = '0;
      cnt_d     = cnt_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (pick_valid) begin
               grant_d = pick_gnt;
               idx_d   = pick_idx;
               dev_d   = pick_dev;
               word_d  = pick_word;
               wdata_d = pick_wdata;
               byte_d  = pick_byte;
               send_d  = pick_send;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            send_en_d = send_q;
            recv_en_d = ~send_q;
`ifdef ARB_TIMEOUT_EN
            cnt_d     = TIMEOUT_CYC - 24'd1;
`endif
            state_d   = ST_WAIT;
         end
         ST_WAIT: begin
            if (I_done_flag) begin
               send_en_d = 1'b0;
               recv_en_d = 1'b0;
               done_d    = grant_q;
               if (!send_q) rdata_d = I_read_data;
               state_d   = ST_RELEASE;
            end
`ifdef ARB_TIMEOUT_EN
            else if (cnt_q == '0) begin
               send_en_d = 1'b0;
               recv_en_d = 1'b0;
               done_d    = grant_q;
               err_d     = grant_q;
               state_d   = ST_RELEASE;
            end else begin
               cnt_d = cnt_q - 24'd1;
            end
`endif
         end
         ST_RELEASE: begin
            if ((req & grant_q) == '0) begin
               grant_d = '0;
               ptr_d   = ptr_next;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge I_clk or posedge I_rst) begin
      if (I_rst) begin
         state_q   <= ST_IDLE;
         grant_q   <= '0;
         idx_q     <= '0;
         ptr_q     <= '0;
         dev_q     <= '0;
         word_q    <= '0;
         wdata_q   <= '0;
         byte_q    <= '0;
         send_q    <= 1'b0;
         send_en_q <= 1'b0;
         recv_en_q <= 1'b0;
         done_q    <= '0;
         rdata_q   <= '0;
`ifdef ARB_TIMEOUT_EN
         err_q     <= '0;
         cnt_q     <= '0;
`endif
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         idx_q     <= idx_d;
         ptr_q     <= ptr_d;
         dev_q     <= dev_d;
         word_q    <= word_d;
         wdata_q   <= wdata_d;
         byte_q    <= byte_d;
         send_q    <= send_d;
         send_en_q <= send_en_d;
         recv_en_q <= recv_en_d;
         done_q    <= done_d;
         rdata_q   <= rdata_d;
`ifdef ARB_TIMEOUT_EN
         err_q     <= err_d;
         cnt_q     <= cnt_d;
`endif
      end
   end

   assign O_grant      = grant_q;
   assign O_req_done   = done_q;
   assign O_read_data  = rdata_q;
   assign O_send_en    = send_en_q;
   assign O_recv_en    = recv_en_q;
   assign O_dev_addr   = dev_q;
   assign O_word_addr  = word_q;
   assign O_write_data = wdata_q;
   assign O_byte       = byte_q;
`ifdef ARB_TIMEOUT_EN
   assign O_req_err    = err_q;
`else
   assign O_req_err    = '0;
`endif

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Scoreboard bench for i2c_master_arbiter: a monitor checks every master
// transaction start and every done pulse against hand-computed expectations.
module tb_i2c_master_arbiter;

   localparam int N = 4;

   typedef struct packed {
      logic [3:0] grant;
      logic       send;
      logic [6:0] dev;
      logic [7:0] word;
      logic [7:0] wdata;
      logic [1:0] nb;
   } mexp_t;

   typedef struct packed {
      logic [3:0]  done;
      logic [3:0]  err;
      logic [15:0] rd;
   } dexp_t;

   logic           clk;
   logic           rst;
   logic [N-1:0]   req_send, req_recv;
   logic [7*N-1:0] req_dev;
   logic [8*N-1:0] req_word, req_wdata;
   logic [2*N-1:0] req_byte;
   logic [N-1:0]   O_grant, O_req_done, O_req_err;
   logic [15:0]    O_read_data;
   logic           O_send_en, O_recv_en;
   logic [6:0]     O_dev_addr;
   logic [7:0]     O_word_addr, O_write_data;
   logic [1:0]     O_byte;
   logic           done_flag;
   logic [15:0]    rd_data;

   logic [6:0] dev_a   [N];
   logic [7:0] word_a  [N];
   logic [7:0] wdata_a [N];
   logic [1:0] byte_a  [N];
   logic [N-1:0] sv_send, sv_recv, reraise;
   int           rereq_left [N];

   logic         m_mute;
   int           m_cnt;
   logic [15:0]  m_rdata;

   mexp_t mq[$];
   dexp_t dq[$];
   int n_cmp, n_bad;

   for (genvar g = 0; g < N; g++) begin : g_pack
      assign req_dev[g*7 +: 7]   = dev_a[g];
      assign req_word[g*8 +: 8]  = word_a[g];
      assign req_wdata[g*8 +: 8] = wdata_a[g];
      assign req_byte[g*2 +: 2]  = byte_a[g];
   end

   i2c_master_arbiter #(.N_REQ(N), .TIMEOUT_CYC(24'd100)) dut (
      .I_clk            (clk),
      .I_rst            (rst),
      .I_req_send       (req_send),
      .I_req_recv       (req_recv),
      .I_req_dev_addr   (req_dev),
      .I_req_word_addr  (req_word),
      .I_req_write_data (req_wdata),
      .I_req_byte       (req_byte),
      .O_grant          (O_grant),
      .O_req_done       (O_req_done),
      .O_req_err        (O_req_err),
      .O_read_data      (O_read_data),
      .O_send_en        (O_send_en),
      .O_recv_en        (O_recv_en),
      .O_dev_addr       (O_dev_addr),
      .O_word_addr      (O_word_addr),
      .O_write_data     (O_write_data),
      .O_byte           (O_byte),
      .I_done_flag      (done_flag),
      .I_read_data      (rd_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic push_m(input logic [3:0] g, input logic s, input logic [6:0] d,
                         input logic [7:0] w, input logic [7:0] wd, input logic [1:0] b);
      mexp_t e;
      e.grant = g; e.send = s; e.dev = d; e.word = w; e.wdata = wd; e.nb = b;
      mq.push_back(e);
   endtask

   task automatic push_d(input logic [3:0] dn, input logic [3:0] er, input logic [15:0] rd);
      dexp_t e;
      e.done = dn; e.err = er; e.rd = rd;
      dq.push_back(e);
   endtask

   task automatic raise(input int i, input logic s, input logic r, input logic [6:0] d,
                        input logic [7:0] w, input logic [7:0] wd, input logic [1:0] b);
      dev_a[i] = d; word_a[i] = w; wdata_a[i] = wd; byte_a[i] = b;
      sv_send[i] = s; sv_recv[i] = r;
      req_send[i] = s; req_recv[i] = r;
   endtask

   // One clock: requester models drop on done (optionally re-raise one cycle
   // later); master model answers done 3 cycles after its enable rises.
   task automatic tick();
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         if (reraise[i]) begin
            req_send[i] = sv_send[i];
            req_recv[i] = sv_recv[i];
            reraise[i]  = 1'b0;
         end else if (O_req_done[i]) begin
            req_send[i] = 1'b0;
            req_recv[i] = 1'b0;
            if (rereq_left[i] > 0) begin
               rereq_left[i]--;
               reraise[i] = 1'b1;
            end
         end
      end
      if (done_flag) begin
         done_flag = 1'b0;
         m_cnt     = 0;
      end else if ((O_send_en || O_recv_en) && !m_mute) begin
         m_cnt++;
         if (m_cnt == 3) begin
            done_flag = 1'b1;
            rd_data   = m_rdata;
         end
      end else begin
         m_cnt = 0;
      end
   endtask

   task automatic wait_quiet(input int budget, input string tag);
      int n;
      n = 0;
      while ((mq.size() != 0 || dq.size() != 0 || O_grant != 0 ||
              (req_send | req_recv) != 0 || reraise != 0) && n < budget) begin
         tick();
         n++;
      end
      n_cmp++;
      if (n >= budget) begin
         n_bad++;
         $display("FAIL %s_quiet: still busy after %0d cycles, mq=%0d dq=%0d grant=%b",
                  tag, n, mq.size(), dq.size(), O_grant);
      end
   endtask

   task automatic monitor();
      logic  en_prev;
      mexp_t me, mg;
      dexp_t de, dg;
      en_prev = 1'b0;
      forever begin
         @(negedge clk);
         if ((O_send_en || O_recv_en) && !en_prev) begin
            n_cmp++;
            mg.grant = O_grant; mg.send = O_send_en; mg.dev = O_dev_addr;
            mg.word = O_word_addr; mg.wdata = O_write_data; mg.nb = O_byte;
            if (mq.size() == 0) begin
               n_bad++;
               $display("FAIL master_txn: unexpected start got %h", mg);
            end else begin
               me = mq.pop_front();
               if (mg !== me || O_recv_en !== ~me.send) begin
                  n_bad++;
                  $display("FAIL master_txn: got %h recv=%b expected %h", mg, O_recv_en, me);
               end
            end
         end
         en_prev = O_send_en || O_recv_en;
         if (O_req_done != '0) begin
            n_cmp++;
            dg.done = O_req_done; dg.err = O_req_err; dg.rd = O_read_data;
            if (dq.size() == 0) begin
               n_bad++;
               $display("FAIL done_pulse: unexpected got %h", dg);
            end else begin
               de = dq.pop_front();
               if (dg !== de) begin
                  n_bad++;
                  $display("FAIL done_pulse: got %h expected %h", dg, de);
               end
            end
         end
      end
   endtask

   initial begin
      int n;
      rst = 1'b1;
      req_send = '0; req_recv = '0;
      done_flag = 1'b0; rd_data = '0;
      m_mute = 1'b0; m_cnt = 0; m_rdata = '0;
      sv_send = '0; sv_recv = '0; reraise = '0;
      n_cmp = 0; n_bad = 0;
      for (int i = 0; i < N; i++) begin
         dev_a[i] = '0; word_a[i] = '0; wdata_a[i] = '0; byte_a[i] = '0;
         rereq_left[i] = 0;
      end
      fork
         monitor();
      join_none

      repeat (3) @(posedge clk);
      #1;
      check("rst_grant", 32'(O_grant), 32'h0);
      check("rst_en", {30'h0, O_send_en, O_recv_en}, 32'h0);
      check("rst_done_err", {24'h0, O_req_done, O_req_err}, 32'h0);
      check("rst_rdata", 32'(O_read_data), 32'h0);
      check("rst_fields", {7'h0, O_dev_addr, O_word_addr, O_write_data, O_byte}, 32'h0);
      rst = 1'b0;

      // stray master done while idle must be ignored
      tick();
      rd_data = 16'hFFFF;
      done_flag = 1'b1;
      tick();
      check("idle_done_ignored", 32'(O_req_done), 32'h0);
      check("idle_rdata_kept", 32'(O_read_data), 32'h0);
      tick();

      // three simultaneous requests, pointer 0 -> 0, 1, 3
      m_rdata = 16'h1234;
      raise(0, 1'b1, 1'b0, 7'h10, 8'h01, 8'h11, 2'd1);
      raise(1, 1'b0, 1'b1, 7'h11, 8'h02, 8'h22, 2'd2);
      raise(3, 1'b1, 1'b0, 7'h13, 8'h04, 8'h44, 2'd0);
      push_m(4'b0001, 1'b1, 7'h10, 8'h01, 8'h11, 2'd1); push_d(4'b0001, 4'b0, 16'h0000);
      push_m(4'b0010, 1'b0, 7'h11, 8'h02, 8'h22, 2'd2); push_d(4'b0010, 4'b0, 16'h1234);
      push_m(4'b1000, 1'b1, 7'h13, 8'h04, 8'h44, 2'd0); push_d(4'b1000, 4'b0, 16'h1234);
      wait_quiet(300, "t2");

      // pointer wrapped to 0: req0 (send+recv -> send) first, then req2, then req0 again
      raise(0, 1'b1, 1'b1, 7'h40, 8'h00, 8'h80, 2'd1);
      raise(2, 1'b1, 1'b0, 7'h22, 8'h33, 8'h44, 2'd1);
      rereq_left[0] = 1;
      push_m(4'b0001, 1'b1, 7'h40, 8'h00, 8'h80, 2'd1); push_d(4'b0001, 4'b0, 16'h1234);
      push_m(4'b0100, 1'b1, 7'h22, 8'h33, 8'h44, 2'd1); push_d(4'b0100, 4'b0, 16'h1234);
      push_m(4'b0001, 1'b1, 7'h40, 8'h00, 8'h80, 2'd1); push_d(4'b0001, 4'b0, 16'h1234);
      wait_quiet(300, "t3");

      // single read on req1: enable after 2 cycles, fields frozen in WAIT
      m_rdata = 16'hABC0;
      raise(1, 1'b0, 1'b1, 7'h6F, 8'h1E, 8'h00, 2'd2);
      push_m(4'b0010, 1'b0, 7'h6F, 8'h1E, 8'h00, 2'd2); push_d(4'b0010, 4'b0, 16'hABC0);
      tick();
      check("t1_grant_1cyc", 32'(O_grant), 32'h2);
      check("t1_en_1cyc", 32'(O_recv_en), 32'h0);
      tick();
      check("t1_en_2cyc", 32'(O_recv_en), 32'h1);
      word_a[1] = 8'hFF;
      dev_a[1]  = 7'h00;
      tick();
      check("t1_frozen", {17'h0, O_dev_addr, O_word_addr}, {17'h0, 7'h6F, 8'h1E});
      wait_quiet(100, "t1");
      check("t1_rdata_held", 32'(O_read_data), 32'hABC0);

      // reset mid-WAIT (pointer 2 -> req3 owns), then lowest index wins
      raise(3, 1'b0, 1'b1, 7'h33, 8'h55, 8'h00, 2'd2);
      raise(1, 1'b1, 1'b0, 7'h31, 8'h56, 8'h66, 2'd1);
      push_m(4'b1000, 1'b0, 7'h33, 8'h55, 8'h00, 2'd2);
      m_mute = 1'b1;
      n = 0;
      while (!O_recv_en && n < 20) begin
         tick();
         n++;
      end
      check("t6_reached_wait", 32'(O_recv_en), 32'h1);
      tick();
      #2 rst = 1'b1;
      #1;
      check("t6_rst_grant", 32'(O_grant), 32'h0);
      check("t6_rst_en", {30'h0, O_send_en, O_recv_en}, 32'h0);
      check("t6_rst_rdata", 32'(O_read_data), 32'h0);
      tick();
      tick();
      m_mute  = 1'b0;
      m_rdata = 16'h5A5A;
      push_m(4'b0010, 1'b1, 7'h31, 8'h56, 8'h66, 2'd1); push_d(4'b0010, 4'b0, 16'h0000);
      push_m(4'b1000, 1'b0, 7'h33, 8'h55, 8'h00, 2'd2); push_d(4'b1000, 4'b0, 16'h5A5A);
      rst = 1'b0;
      tick();
      check("t6_first_grant", 32'(O_grant), 32'h2);
      wait_quiet(300, "t6");

`ifdef ARB_TIMEOUT_EN
      // silent master: watchdog ends req0 after 100 WAIT cycles, then req1 served
      raise(0, 1'b0, 1'b1, 7'h50, 8'h60, 8'h00, 2'd2);
      raise(1, 1'b1, 1'b0, 7'h51, 8'h61, 8'h71, 2'd1);
      push_m(4'b0001, 1'b0, 7'h50, 8'h60, 8'h00, 2'd2); push_d(4'b0001, 4'b0001, 16'h5A5A);
      push_m(4'b0010, 1'b1, 7'h51, 8'h61, 8'h71, 2'd1); push_d(4'b0010, 4'b0, 16'h5A5A);
      m_mute = 1'b1;
      n = 0;
      while (!O_recv_en && n < 20) begin
         tick();
         n++;
      end
      n = 1;
      while (O_recv_en && n < 300) begin
         tick();
         if (O_recv_en) n++;
      end
      check("t5_wait_cycles", 32'(n), 32'd100);
      check("t5_done_err", {24'h0, O_req_done, O_req_err}, {24'h0, 4'b0001, 4'b0001});
      m_mute = 1'b0;
      wait_quiet(300, "t5");
`endif

      repeat (3) tick();
      check("sb_mq_empty", 32'(mq.size()), 32'h0);
      check("sb_dq_empty", 32'(dq.size()), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
